// File: rtl/sysid_regs_pkg.sv
// Shared constants for the system-ID register block: word map, CTRL bit
// positions and datapath widths.
package sysid_regs_pkg;

  localparam int DATA_W   = 32;
  localparam int UPTIME_W = 64;

  localparam int ADDR_ID        = 0;
  localparam int ADDR_TS        = 1;
  localparam int ADDR_VER       = 2;
  localparam int ADDR_SCRATCH   = 3;
  localparam int ADDR_UPTIME_LO = 4;
  localparam int ADDR_UPTIME_HI = 5;
  localparam int ADDR_CTRL      = 6;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_FREEZE = 1;

endpackage : sysid_regs_pkg

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit cycle counter with synchronous clear (which wins over
// increment) and a freeze input. It wraps silently.
module sysid_uptime_counter
  import sysid_regs_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                freeze,
  output logic [UPTIME_W-1:0] count
);

  logic [UPTIME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)          count_d = '0;
    else if (!freeze) count_d = count_q + UPTIME_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule : sysid_uptime_counter

// File: rtl/sysid_regs_ext.sv
// Registered Avalon-MM system-ID slave: build identity words, scratch
// register, 64-bit uptime counter with atomic LO/HI readout, and CTRL.
module sysid_regs_ext
  import sysid_regs_pkg::*;
#(
  parameter logic [31:0] SYS_ID      = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          ADDR_W      = 3,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic [DATA_W-1:0]   scratch_q, scratch_d;
  logic [DATA_W-1:0]   hi_snap_q, hi_snap_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                freeze_q, freeze_d;
  logic                cnt_clr;
  logic [UPTIME_W-1:0] uptime;
  logic                rd_en;

  // A write in the same cycle as a read takes the bus; the read is dropped.
  assign rd_en = read && !write;

  sysid_uptime_counter u_uptime (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr),
    .freeze (freeze_q),
    .count  (uptime)
  );

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    scratch_d = scratch_q;
    hi_snap_d = hi_snap_q;
    rdata_d   = rdata_q;
    rvalid_d  = rd_en;
    freeze_d  = freeze_q;
    cnt_clr   = 1'b0;

    if (write) begin
      case (int'(address))
        ADDR_SCRATCH: begin
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
        // A clear command leaves freeze untouched; otherwise bit1 loads freeze.
        ADDR_CTRL: begin
          if (byteenable[0]) begin
            if (writedata[CTRL_CLR]) cnt_clr  = 1'b1;
            else                     freeze_d = writedata[CTRL_FREEZE];
          end
        end
        default: ;
      endcase
    end

    if (rd_en) begin
      rdata_d = '0;
      case (int'(address))
        ADDR_ID:        rdata_d = SYS_ID;
        ADDR_TS:        rdata_d = TIMESTAMP;
        ADDR_VER:       rdata_d = VERSION;
        ADDR_SCRATCH:   rdata_d = scratch_q;
        ADDR_UPTIME_LO: begin
          rdata_d   = uptime[DATA_W-1:0];
          hi_snap_d = uptime[UPTIME_W-1:DATA_W];
        end
        ADDR_UPTIME_HI: rdata_d = hi_snap_q;
        ADDR_CTRL:      rdata_d[CTRL_FREEZE] = freeze_q;
        default:        rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q <= SCRATCH_RST;
      hi_snap_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      hi_snap_q <= hi_snap_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      freeze_q  <= freeze_d;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule : sysid_regs_ext

// File: tb/tb_sysid_regs_ext.sv
// Self-checking bench for sysid_regs_ext: directed register-map checks plus
// randomized bus traffic compared against a behavioural model.
module tb_sysid_regs_ext;

  localparam logic [31:0] P_SYS_ID  = 32'h5545_A80E;
  localparam logic [31:0] P_TS      = 32'h6650_1234;
  localparam logic [31:0] P_VER     = 32'h0002_0003;
  localparam logic [31:0] P_SCR_RST = 32'hA5A5_0F0F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [63:0] m_up;
  logic [31:0] m_hi, m_scr, m_data;
  logic        m_frz;

  sysid_regs_ext #(
    .SYS_ID      (P_SYS_ID),
    .TIMESTAMP   (P_TS),
    .VERSION     (P_VER),
    .ADDR_W      (3),
    .SCRATCH_RST (P_SCR_RST)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_up = '0; m_hi = '0; m_scr = P_SCR_RST; m_data = '0; m_frz = 1'b0;
  endtask

  // One bus cycle: drive at the falling edge, update the model at the rising
  // edge, check 1 time unit later, return at the next falling edge.
  task automatic cycle(input string tag, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [31:0] wd,
                       input logic [3:0] be);
    logic exp_valid;
    logic clr;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    @(posedge clock);
    exp_valid = rd && !wr;
    if (exp_valid) begin
      case (a)
        3'd0: m_data = P_SYS_ID;
        3'd1: m_data = P_TS;
        3'd2: m_data = P_VER;
        3'd3: m_data = m_scr;
        3'd4: begin m_data = m_up[31:0]; m_hi = m_up[63:32]; end
        3'd5: m_data = m_hi;
        3'd6: m_data = {30'd0, m_frz, 1'b0};
        default: m_data = 32'd0;
      endcase
    end
    clr = wr && a == 3'd6 && be[0] && wd[0];
    if (clr)         m_up = '0;
    else if (!m_frz) m_up = m_up + 64'd1;
    if (wr && a == 3'd3)
      for (int i = 0; i < 4; i++) if (be[i]) m_scr[8*i +: 8] = wd[8*i +: 8];
    if (wr && a == 3'd6 && be[0] && !wd[0]) m_frz = wd[1];
    #1;
    check({tag, ".valid"}, {31'd0, readdatavalid}, {31'd0, exp_valid});
    check({tag, ".data"}, readdata, m_data);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle", 1'b0, 1'b0, 3'd0, 32'd0, 4'h0);
  endtask

  initial begin
    logic [31:0] first_lo;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst.valid", {31'd0, readdatavalid}, 32'd0);
    check("rst.data", readdata, 32'd0);

    // Identity words
    cycle("rd_id",  1, 0, 3'd0, 0, 4'h0);
    check("id_abs", readdata, 32'h5545_A80E);
    cycle("rd_ts",  1, 0, 3'd1, 0, 4'h0);
    cycle("rd_ver", 1, 0, 3'd2, 0, 4'h0);
    check("ver_abs", readdata, 32'h0002_0003);

    // Scratch byte lanes
    cycle("wr_scr_full", 0, 1, 3'd3, 32'hDEAD_BEEF, 4'b1111);
    cycle("wr_scr_b0",   0, 1, 3'd3, 32'h0000_0011, 4'b0001);
    cycle("rd_scr",      1, 0, 3'd3, 0, 4'h0);
    check("scr_abs", readdata, 32'hDEAD_BE11);

    // Atomic LO/HI across a carry
    force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFF;
    #1 release dut.u_uptime.count_q;
    m_up = 64'h0000_0001_FFFF_FFFF;
    cycle("rd_lo_carry", 1, 0, 3'd4, 0, 4'h0);
    check("lo_abs", readdata, 32'hFFFF_FFFF);
    idle(1);
    cycle("rd_hi_carry", 1, 0, 3'd5, 0, 4'h0);
    check("hi_abs", readdata, 32'h0000_0001);

    // Freeze, then clear while frozen
    cycle("wr_frz", 0, 1, 3'd6, 32'h2, 4'hF);
    idle(10);
    cycle("rd_lo_frz1", 1, 0, 3'd4, 0, 4'h0);
    first_lo = readdata;
    cycle("rd_lo_frz2", 1, 0, 3'd4, 0, 4'h0);
    check("frz_equal", readdata, first_lo);
    cycle("wr_clr", 0, 1, 3'd6, 32'h1, 4'hF);
    cycle("rd_lo_clr", 1, 0, 3'd4, 0, 4'h0);
    check("clr_abs", readdata, 32'd0);
    cycle("rd_ctrl", 1, 0, 3'd6, 0, 4'h0);
    check("ctrl_abs", readdata, 32'h2);
    cycle("wr_unfrz", 0, 1, 3'd6, 32'h0, 4'hF);

    // Simultaneous read+write, back-to-back reads, unmapped word
    cycle("rdwr", 1, 1, 3'd3, 32'h1234_5678, 4'hF);
    cycle("rd_after_rdwr", 1, 0, 3'd3, 0, 4'h0);
    check("rdwr_abs", readdata, 32'h1234_5678);
    cycle("rd_b2b_a", 1, 0, 3'd0, 0, 4'h0);
    cycle("rd_b2b_b", 1, 0, 3'd7, 0, 4'h0);
    check("unmapped_abs", readdata, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom),
            $urandom, 4'($urandom));

    // Reset in the middle of a read
    read = 1'b1; address = 3'd0;
    #4 reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid.valid", {31'd0, readdatavalid}, 32'd0);
    check("rst_mid.data", readdata, 32'd0);
    @(negedge clock);
    read = 1'b0; reset = 1'b0;
    model_reset();
    cycle("rd_scr_rst", 1, 0, 3'd3, 0, 4'h0);
    check("scr_rst_abs", readdata, P_SCR_RST);
    cycle("rd_unmapped", 1, 0, 3'd7, 0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sysid_regs_ext
